branch_history_table: RTL and testbench
=======================================

# branch_history_table

Direct-mapped branch history table of n-bit saturating counters that supplies taken/not-taken predictions to the fetch stage and is trained by resolved branches from the execute stage. It sits beside the PC register in fetch. Its registered prediction output drives the next-PC select mux, choosing between PC+4 and the branch target. It also counts mispredictions for performance monitoring.

## Interface
- ENTRIES, 64: number of counters; power of two, ≥2; IDX_BITS = clog2(ENTRIES)
- CTR_WIDTH, 2: bits per saturating counter, ≥1
- MISS_WIDTH, 16: width of misprediction counter
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- predict_valid  in  1  fetch requests a prediction this cycle
- predict_stall  in  1  fetch stalled; hold prediction outputs
- predict_pc  in  32  PC of the instruction being fetched
- predict_valid_out  out  1  registered: prediction_taken is valid
- predict_taken  out  1  registered prediction, 1 = taken
- update_valid  in  1  execute has resolved a conditional branch
- update_pc  in  32  PC of the resolved branch
- update_taken  in  1  actual outcome
- update_predicted  in  1  prediction that was used for this branch
- miss_count  out  MISS_WIDTH  saturating count of mispredictions

## Operation
- Index = pc[IDX_BITS+1:2], the same formula for predict and update. PC bits [1:0] and above IDX_BITS+1 are ignored, so aliasing is permitted.
- Counter array ctr[ENTRIES], each CTR_WIDTH bits. Reset value of every entry is 1, which is weakly not-taken for CTR_WIDTH=2.
- Prediction is taken iff the MSB of the counter is 1.
- Update applies when update_valid=1:
  - update_taken=1: ctr += 1 unless ctr = 2^CTR_WIDTH−1.
  - update_taken=0: ctr −= 1 unless ctr = 0.
  - Saturation: never wraps.
- Misprediction counting: when update_valid=1 and update_predicted≠update_taken, miss_count += 1. miss_count saturates at all-ones and never wraps.
- Forwarding: if update_valid and predict_valid occur in the same cycle with equal indices, the prediction uses the post-update counter value.
- Stall: when predict_stall=1, predict_valid_out and predict_taken hold their values and predict_valid/predict_pc are ignored. Updates still apply during a stall.
- Bubble: when predict_stall=0 and predict_valid=0, the next edge loads predict_valid_out=0 and predict_taken=0.
- Reset mid-operation:
  - All counters return to 1 immediately; the table has no pending-operation state.
  - predict_valid_out, predict_taken and miss_count clear immediately.
  - An update presented in the reset cycle is discarded.

## Timing
- Reset values: predict_valid_out=0, predict_taken=0, miss_count=0, all ctr=1.
- Prediction latency is 1 cycle. Request at edge N produces predict_valid_out/predict_taken after edge N+1.
- Update latency is 1 cycle. The counter write occurs at the edge where update_valid is sampled, so it is visible to any later predict, and to a same-cycle predict via forwarding.
- miss_count updates at the same edge as the counter write.
- Throughput: one predict and one update per cycle, independent and with no backpressure.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- Reset, then predict_pc=0x100 -> predict_valid_out=1, predict_taken=0 one cycle later; miss_count=0.
- Two updates to 0x100 with update_taken=1, update_predicted=0 -> counter 1→2→3. Predict 0x100 -> taken=1. miss_count=2.
- Three more taken updates to 0x100 keep the counter at 3. Then:
  - One not-taken update -> predict taken=1 (ctr=2).
  - A second not-taken update -> taken=0 (ctr=1).
  - Three more not-taken updates -> ctr stays 0, and a following taken update gives ctr=1.
- Aliasing and forwarding (ENTRIES=64):
  - Train 0x100 to 3, then predict 0x200 (same index 0) -> taken=1. Predict 0x104 -> taken=0.
  - With ctr[1]=1, assert in the same cycle update_pc=0x104 taken and predict_pc=0x104 -> predict_taken=1.
- Stall: request 0x100 (taken), then assert predict_stall for 3 cycles while requesting 0x104 -> outputs hold 1/1 for all 3 cycles. Deassert with predict_valid=0 -> valid_out=0.
- Saturation of miss_count with MISS_WIDTH=4: apply 17 mispredicted updates -> miss_count=15.
- Reset mid-operation: assert reset asynchronously between edges -> outputs clear immediately. After release, predict 0x100 -> taken=0.

Source files
------------

// File: rtl/branch_history_table.sv
// branch_history_table
//   Direct-mapped table of saturating counters. It gives taken/not-taken
//   predictions to fetch and is trained by resolved branches from execute.
//   Ports:
//     clk, reset               clock; asynchronous active-high reset
//     predict_valid/_stall/_pc prediction request, stall hold, fetch PC
//     predict_valid_out        registered: predict_taken is meaningful
//     predict_taken            registered prediction (1 = taken)
//     update_valid/_pc         resolved-branch training request
//     update_taken             actual outcome
//     update_predicted         prediction that fetch used for this branch
//     miss_count               saturating misprediction count

// One table entry. ctr_nxt is the value the entry will hold after this
// edge. It is also the forwarded value for a same-cycle predict.
module bht_ctr #(
  parameter int CTR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 upd_en,
  input  logic                 upd_taken,
  output logic [CTR_WIDTH-1:0] ctr_nxt
);
  logic [CTR_WIDTH-1:0] ctr_q;

  always_comb begin
    ctr_nxt = ctr_q;
    if (upd_en) begin
      if (upd_taken && (ctr_q != {CTR_WIDTH{1'b1}}))
        ctr_nxt = ctr_q + 1'b1;
      else if (!upd_taken && (ctr_q != '0))
        ctr_nxt = ctr_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ctr_q <= CTR_WIDTH'(1);
    else       ctr_q <= ctr_nxt;
  end
endmodule

module branch_history_table #(
  parameter int ENTRIES    = 64,
  parameter int CTR_WIDTH  = 2,
  parameter int MISS_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  predict_valid,
  input  logic                  predict_stall,
  input  logic [31:0]           predict_pc,
  output logic                  predict_valid_out,
  output logic                  predict_taken,
  input  logic                  update_valid,
  input  logic [31:0]           update_pc,
  input  logic                  update_taken,
  input  logic                  update_predicted,
  output logic [MISS_WIDTH-1:0] miss_count
);
  localparam int IDX_BITS = $clog2(ENTRIES);

  logic [IDX_BITS-1:0]                pred_idx, upd_idx;
  logic [ENTRIES-1:0][CTR_WIDTH-1:0]  ctr_nxt;
  logic                               mispredict;

  // Word-aligned index. Upper PC bits alias, so they are ignored on purpose.
  assign pred_idx = predict_pc[IDX_BITS+1:2];
  assign upd_idx  = update_pc[IDX_BITS+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{predict_pc[31:IDX_BITS+2], predict_pc[1:0],
                            update_pc[31:IDX_BITS+2],  update_pc[1:0]};

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
    bht_ctr #(.CTR_WIDTH(CTR_WIDTH)) u_ctr (
      .clk       (clk),
      .reset     (reset),
      .upd_en    (update_valid && (upd_idx == IDX_BITS'(e))),
      .upd_taken (update_taken),
      .ctr_nxt   (ctr_nxt[e])
    );
  end

  // Reading the post-update value covers same-index forwarding. Entries
  // that are not being updated have ctr_nxt equal to their stored value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      predict_valid_out <= 1'b0;
      predict_taken     <= 1'b0;
    end else if (!predict_stall) begin
      predict_valid_out <= predict_valid;
      predict_taken     <= predict_valid & ctr_nxt[pred_idx][CTR_WIDTH-1];
    end
  end

  assign mispredict = update_valid && (update_taken != update_predicted);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      miss_count <= '0;
    else if (mispredict && (miss_count != {MISS_WIDTH{1'b1}}))
      miss_count <= miss_count + 1'b1;
  end
endmodule

// File: tb/tb_branch_history_table.sv
module tb_branch_history_table;
  localparam int ENT  = 64;
  localparam int CW   = 2;
  localparam int MW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int MMAX = (1 << MW) - 1;
  localparam int THR  = 1 << (CW - 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pv = 1'b0, stall = 1'b0;
  logic [31:0]   pc_p = '0, pc_u = '0;
  logic          uv = 1'b0, ut = 1'b0, upr = 1'b0;
  logic          vo, tk;
  logic [MW-1:0] miss;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one integer counter per table slot.
  int   m_ctr [ENT];
  int   m_miss;
  logic e_vo, e_t;

  branch_history_table #(.ENTRIES(ENT), .CTR_WIDTH(CW), .MISS_WIDTH(MW)) dut (
    .clk               (clk),
    .reset             (reset),
    .predict_valid     (pv),
    .predict_stall     (stall),
    .predict_pc        (pc_p),
    .predict_valid_out (vo),
    .predict_taken     (tk),
    .update_valid      (uv),
    .update_pc         (pc_u),
    .update_taken      (ut),
    .update_predicted  (upr),
    .miss_count        (miss)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) m_ctr[i] = 1;
    m_miss = 0;
    e_vo   = 1'b0;
    e_t    = 1'b0;
  endtask

  // Advance the model by one edge with the current inputs, then move to
  // just after that edge so outputs are stable for sampling.
  task automatic tick();
    int pi, ui;
    pi = (pc_p / 4) % ENT;
    ui = (pc_u / 4) % ENT;
    if (uv) begin
      if (ut) m_ctr[ui] = (m_ctr[ui] == CMAX) ? CMAX : m_ctr[ui] + 1;
      else    m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
      if (ut != upr && m_miss < MMAX) m_miss = m_miss + 1;
    end
    if (!stall) begin
      e_vo = pv;
      e_t  = pv && (m_ctr[pi] >= THR);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pred(input logic [31:0] pc);
    pv = 1'b1; pc_p = pc;
    tick();
    pv = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic p);
    uv = 1'b1; pc_u = pc; ut = t; upr = p;
    tick();
    uv = 1'b0;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    model_reset();
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    n_cmp++; if (vo !== 1'b0) begin n_err++; $display("FAIL reset_vo: got %0b want 0", vo); end
    n_cmp++; if (tk !== 1'b0) begin n_err++; $display("FAIL reset_taken: got %0b want 0", tk); end
    n_cmp++; if (miss !== '0) begin n_err++; $display("FAIL reset_miss: got %0d want 0", miss); end
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    pred(32'h100);
    n_cmp++; if (vo !== 1'b1) begin n_err++; $display("FAIL basic_vo: got %0b want 1", vo); end
    n_cmp++; if (tk !== 1'b0) begin n_err++; $display("FAIL basic_taken: got %0b want 0", tk); end
    n_cmp++; if (miss !== 4'd0) begin n_err++; $display("FAIL basic_miss: got %0d want 0", miss); end
    tick();
    n_cmp++; if (vo !== 1'b0) begin n_err++; $display("FAIL bubble_vo: got %0b want 0", vo); end
  endtask

  task automatic test_train();
    do_reset();
    upd(32'h100, 1'b1, 1'b0);
    upd(32'h100, 1'b1, 1'b0);
    pred(32'h100);
    n_cmp++; if (tk !== 1'b1) begin n_err++; $display("FAIL train_taken: got %0b want 1", tk); end
    n_cmp++; if (miss !== 4'd2) begin n_err++; $display("FAIL train_miss: got %0d want 2", miss); end
    // Already at the top; three more taken updates must not wrap.
    for (int i = 0; i < 3; i++) upd(32'h100, 1'b1, 1'b1);
    upd(32'h100, 1'b0, 1'b1);
    pred(32'h100);
    n_cmp++; if (tk !== 1'b1) begin n_err++; $display("FAIL sat_hi_taken: got %0b want 1", tk); end
    upd(32'h100, 1'b0, 1'b1);
    pred(32'h100);
    n_cmp++; if (tk !== 1'b0) begin n_err++; $display("FAIL dec_ctr1: got %0b want 0", tk); end
    // Floor at zero: one taken update lands on 1, a second on 2.
    for (int i = 0; i < 3; i++) upd(32'h100, 1'b0, 1'b0);
    upd(32'h100, 1'b1, 1'b0);
    pred(32'h100);
    n_cmp++; if (tk !== 1'b0) begin n_err++; $display("FAIL sat_lo_ctr1: got %0b want 0", tk); end
    upd(32'h100, 1'b1, 1'b0);
    pred(32'h100);
    n_cmp++; if (tk !== 1'b1) begin n_err++; $display("FAIL sat_lo_ctr2: got %0b want 1", tk); end
  endtask

  task automatic test_alias_forward();
    do_reset();
    upd(32'h100, 1'b1, 1'b0);
    upd(32'h100, 1'b1, 1'b0);
    pred(32'h200);
    n_cmp++; if (tk !== 1'b1) begin n_err++; $display("FAIL alias_taken: got %0b want 1", tk); end
    pred(32'h104);
    n_cmp++; if (tk !== 1'b0) begin n_err++; $display("FAIL alias_other: got %0b want 0", tk); end
    // Same-cycle update and predict to one index uses the post-update count.
    uv = 1'b1; pc_u = 32'h104; ut = 1'b1; upr = 1'b0;
    pv = 1'b1; pc_p = 32'h104;
    tick();
    uv = 1'b0; pv = 1'b0;
    n_cmp++; if (tk !== 1'b1) begin n_err++; $display("FAIL fwd_taken: got %0b want 1", tk); end
    // Different indices in the same cycle: no forwarding.
    uv = 1'b1; pc_u = 32'h108; ut = 1'b1; upr = 1'b0;
    pv = 1'b1; pc_p = 32'h10c;
    tick();
    uv = 1'b0; pv = 1'b0;
    n_cmp++; if (tk !== 1'b0) begin n_err++; $display("FAIL fwd_noalias: got %0b want 0", tk); end
  endtask

  task automatic test_stall();
    do_reset();
    upd(32'h100, 1'b1, 1'b0);
    upd(32'h100, 1'b1, 1'b0);
    pred(32'h100);
    stall = 1'b1; pv = 1'b1; pc_p = 32'h104;
    for (int i = 0; i < 3; i++) begin
      // Training still happens underneath a stall.
      uv = (i < 2); pc_u = 32'h108; ut = 1'b1; upr = 1'b1;
      tick();
      n_cmp++; if ({vo, tk} !== 2'b11) begin n_err++; $display("FAIL stall_hold%0d: got %b want 11", i, {vo, tk}); end
    end
    uv = 1'b0; stall = 1'b0; pv = 1'b0;
    tick();
    n_cmp++; if ({vo, tk} !== 2'b00) begin n_err++; $display("FAIL stall_release: got %b want 00", {vo, tk}); end
    pred(32'h108);
    n_cmp++; if (tk !== 1'b1) begin n_err++; $display("FAIL stall_update: got %0b want 1", tk); end
  endtask

  task automatic test_miss_sat();
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      upd(32'(i * 4), i[0], ~i[0]);
      n_cmp++;
      if (miss !== MW'((i > MMAX) ? MMAX : i)) begin
        n_err++; $display("FAIL miss_sat%0d: got %0d want %0d", i, miss, (i > MMAX) ? MMAX : i);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    upd(32'h100, 1'b1, 1'b0);
    upd(32'h100, 1'b1, 1'b0);
    pv = 1'b1; pc_p = 32'h100;
    uv = 1'b1; pc_u = 32'h100; ut = 1'b0; upr = 1'b1;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({vo, tk} !== 2'b00) begin n_err++; $display("FAIL rstmid_out: got %b want 00", {vo, tk}); end
    n_cmp++; if (miss !== '0) begin n_err++; $display("FAIL rstmid_miss: got %0d want 0", miss); end
    model_reset();
    @(posedge clk);
    #1 pv = 1'b0; uv = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    pred(32'h100);
    n_cmp++; if ({vo, tk} !== 2'b10) begin n_err++; $display("FAIL rstmid_pred: got %b want 10", {vo, tk}); end
    n_cmp++; if (miss !== '0) begin n_err++; $display("FAIL rstmid_miss2: got %0d want 0", miss); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      stall = ($urandom_range(0, 4) == 0);
      pv    = $urandom_range(0, 3) != 0;
      r = $urandom; r[7:2] = 6'($urandom_range(0, 5)); pc_p = r;
      uv    = $urandom_range(0, 2) != 0;
      r = $urandom; r[7:2] = 6'($urandom_range(0, 5)); pc_u = r;
      ut    = 1'($urandom);
      upr   = ($urandom_range(0, 7) == 0) ? ~ut : ut;
      tick();
      n_cmp++;
      if ({vo, tk} !== {e_vo, e_t} || miss !== MW'(m_miss)) begin
        n_err++;
        $display("FAIL random%0d: got vo=%0b t=%0b miss=%0d want vo=%0b t=%0b miss=%0d",
                 c, vo, tk, miss, e_vo, e_t, m_miss);
      end
    end
    stall = 1'b0; pv = 1'b0; uv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_train();
    test_alias_forward();
    test_stall();
    test_miss_sat();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
